// File: rtl/h_sort_unit.sv
// h_sort_unit: captures a group of tagged H entries and streams the valid ones out in ascending column order.
module h_sort_unit #(
   parameter int N_ENT = 35,
   parameter int COL_W = 8,
   parameter int ROW_W = 6
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [N_ENT*(COL_W+ROW_W)-1:0]   H_to_sort,
   input  logic                             load_to_interleaving,
   input  logic                             f_one_iteration,
   output logic                             busy,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [COL_W-1:0]                 out_col,
   output logic [ROW_W-1:0]                 out_row,
   output logic                             out_last,
   output logic [5:0]                       out_cnt,
   output logic                             group_done,
   output logic                             overflow
);
   localparam int W = COL_W + ROW_W;
   localparam logic [N_ENT-1:0] ONE = {{(N_ENT-1){1'b0}}, 1'b1};
   typedef enum logic {IDLE, SORT} state_t;
   state_t state_q, state_d;
   logic [N_ENT-1:0] valid_q, valid_d, in_valid;
   logic [COL_W-1:0] col_q [N_ENT];
   logic [COL_W-1:0] col_d [N_ENT];
   logic [ROW_W-1:0] row_q [N_ENT];
   logic [ROW_W-1:0] row_d [N_ENT];
   logic [5:0] cnt_q, cnt_d, sel;
   logic done_q, done_d, ovf_q, ovf_d;
   logic found, one_left, xfer, capture;
   logic [COL_W-1:0] best_col;
   logic [ROW_W-1:0] best_row;
   always_comb begin
      in_valid = '0;
      for (int i = 0; i < N_ENT; i++) in_valid[i] = |H_to_sort[i*W +: COL_W];
   end
   // strict less-than keeps the lowest index on equal columns
   always_comb begin
      found = 1'b0;
      sel = '0;
      best_col = '0;
      best_row = '0;
      for (int i = 0; i < N_ENT; i++) begin
         if (valid_q[i] && (!found || col_q[i] < best_col)) begin
            found = 1'b1;
            sel = 6'(i);
            best_col = col_q[i];
            best_row = row_q[i];
         end
      end
   end
   assign one_left = |valid_q && ~|(valid_q & (valid_q - ONE));
   assign xfer = out_valid && out_ready;
   assign capture = state_q == IDLE && load_to_interleaving;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      if (f_one_iteration) state_d = IDLE;
      else if (capture) state_d = |in_valid ? SORT : IDLE;
      else if (xfer && one_left) state_d = IDLE;
   end
   always_comb begin
      busy = state_q == SORT;
      out_valid = busy;
      out_col = best_col;
      out_row = best_row;
      out_last = busy && one_left;
      out_cnt = cnt_q;
      group_done = done_q;
      overflow = ovf_q;
   end
   always_comb begin
      valid_d = valid_q;
      col_d = col_q;
      row_d = row_q;
      cnt_d = cnt_q;
      done_d = 1'b0;
      ovf_d = ovf_q | (load_to_interleaving && state_q == SORT);
      if (f_one_iteration) begin
         valid_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (capture) begin
         valid_d = in_valid;
         cnt_d = '0;
         done_d = ~|in_valid;
         for (int i = 0; i < N_ENT; i++) begin
            col_d[i] = H_to_sort[i*W +: COL_W];
            row_d[i] = H_to_sort[i*W+COL_W +: ROW_W];
         end
      end else if (xfer) begin
         valid_d = valid_q & ~(ONE << sel);
         cnt_d = cnt_q + 6'd1;
         done_d = one_left;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         col_q <= '{default: '0};
         row_q <= '{default: '0};
         cnt_q <= '0;
         done_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         col_q <= col_d;
         row_q <= row_d;
         cnt_q <= cnt_d;
         done_q <= done_d;
         ovf_q <= ovf_d;
      end
   end
endmodule

// File: tb/tb_h_sort_unit.sv
// tb_h_sort_unit: table vectors, hand sequences and random groups against an enumerate-by-column reference model.
module tb_h_sort_unit;
   localparam int N = 35;
   localparam int W = 14;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [N*W-1:0] h_in = '0;
   logic load = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic busy, out_valid, out_last, group_done, overflow;
   logic [7:0] out_col;
   logic [5:0] out_row, out_cnt;
   int n_chk = 0, n_fail = 0;
   logic [13:0] exp_q[$];
   typedef struct {
      int n;
      int idx[4];
      int col[4];
      int row[4];
      int ecol[4];
      int erow[4];
   } vec_t;
   vec_t vt[5];
   always #5 clk = ~clk;
   h_sort_unit dut (
      .clk(clk), .rst_n(rst_n), .H_to_sort(h_in), .load_to_interleaving(load),
      .f_one_iteration(flush), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_col(out_col), .out_row(out_row), .out_last(out_last), .out_cnt(out_cnt),
      .group_done(group_done), .overflow(overflow)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask
   task automatic set_ent(input int i, input int c, input int r);
      h_in[i*W +: W] = {r[5:0], c[7:0]};
   endtask
   // reference: walk column values upward, collecting entries in index order
   task automatic model();
      exp_q.delete();
      for (int c = 1; c < 256; c++)
         for (int i = 0; i < N; i++)
            if (h_in[i*W +: 8] == c) exp_q.push_back(h_in[i*W +: W]);
   endtask
   task automatic run_group(input int hold, input int pct);
      int k = 0;
      int cyc = 0;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      if (exp_q.size() == 0) begin
         chk("empty_valid", out_valid, 0);
         chk("empty_busy", busy, 0);
         chk("empty_done", group_done, 1);
         @(negedge clk);
         chk("empty_done_pulse", group_done, 0);
         chk("empty_valid2", out_valid, 0);
         return;
      end
      while (k < exp_q.size() && cyc < 4000) begin
         chk("valid", out_valid, 1);
         chk("col", out_col, exp_q[k][7:0]);
         chk("row", out_row, exp_q[k][13:8]);
         chk("last", out_last, k == exp_q.size() - 1);
         chk("cnt", out_cnt, k);
         chk("done_low", group_done, 0);
         out_ready = (cyc >= hold) && ($urandom_range(99) < pct);
         cyc++;
         @(negedge clk);
         if (out_ready) k++;
      end
      out_ready = 1'b0;
      if (k < exp_q.size()) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d entries expected %0d", k, exp_q.size());
      end
      chk("end_valid", out_valid, 0);
      chk("end_done", group_done, 1);
      chk("end_cnt", out_cnt, exp_q.size());
      chk("end_busy", busy, 0);
      @(negedge clk);
      chk("done_pulse", group_done, 0);
      chk("cnt_hold", out_cnt, exp_q.size());
   endtask
   initial begin
      vt[0] = '{3, '{0, 1, 2, 0}, '{70, 5, 130, 0}, '{0, 1, 2, 0}, '{5, 70, 130, 0}, '{1, 0, 2, 0}};
      vt[1] = '{3, '{4, 9, 33, 0}, '{20, 20, 19, 0}, '{4, 9, 33, 0}, '{19, 20, 20, 0}, '{33, 4, 9, 0}};
      vt[2] = '{3, '{34, 32, 0, 0}, '{255, 1, 255, 0}, '{63, 5, 7, 0}, '{1, 255, 255, 0}, '{5, 7, 63, 0}};
      vt[3] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
      vt[4] = '{1, '{17, 0, 0, 0}, '{128, 0, 0, 0}, '{17, 0, 0, 0}, '{128, 0, 0, 0}, '{17, 0, 0, 0}};
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_col", out_col, 0);
      chk("rst_row", out_row, 0);
      chk("rst_last", out_last, 0);
      chk("rst_cnt", out_cnt, 0);
      chk("rst_done", group_done, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 5; t++) begin
         h_in = '0;
         exp_q.delete();
         for (int j = 0; j < vt[t].n; j++) begin
            set_ent(vt[t].idx[j], vt[t].col[j], vt[t].row[j]);
            exp_q.push_back(14'({vt[t].erow[j][5:0], vt[t].ecol[j][7:0]}));
         end
         run_group(t == 1 ? 3 : 0, 100);
      end
      h_in = '0;
      set_ent(3, 40, 3);
      set_ent(7, 10, 7);
      load = 1'b1;
      @(negedge clk);
      h_in = '0;
      set_ent(0, 1, 0);
      @(negedge clk);
      load = 1'b0;
      chk("ovf_set", overflow, 1);
      chk("ovf_col0", out_col, 10);
      chk("ovf_row0", out_row, 7);
      out_ready = 1'b1;
      @(negedge clk);
      chk("ovf_col1", out_col, 40);
      chk("ovf_last1", out_last, 1);
      @(negedge clk);
      out_ready = 1'b0;
      chk("ovf_done", group_done, 1);
      chk("ovf_cnt", out_cnt, 2);
      @(negedge clk);
      chk("ovf_no_second", out_valid, 0);
      chk("ovf_sticky", overflow, 1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("ovf_cleared", overflow, 0);
      h_in = '0;
      for (int i = 0; i < 10; i++) set_ent(i * 3, $urandom_range(1, 255), i);
      model();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("fl_col", out_col, exp_q[k][7:0]);
         chk("fl_row", out_row, exp_q[k][13:8]);
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("fl_cnt4", out_cnt, 4);
      load = 1'b1;
      @(negedge clk);
      chk("fl_ovf_pre", overflow, 1);
      out_ready = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      load = 1'b0;
      out_ready = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_cnt", out_cnt, 0);
      chk("fl_done", group_done, 0);
      chk("fl_ovf", overflow, 0);
      chk("fl_busy", busy, 0);
      @(negedge clk);
      chk("fl_done2", group_done, 0);
      chk("fl_discard", out_valid, 0);
      h_in = '0;
      set_ent(5, 99, 5);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("re_col", out_col, 99);
      chk("re_last", out_last, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("re_done", group_done, 1);
      chk("re_busy", busy, 0);
      h_in = '0;
      set_ent(2, 50, 2);
      set_ent(8, 30, 8);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("re_valid", out_valid, 1);
      chk("re_col2", out_col, 30);
      chk("re_cnt", out_cnt, 0);
      chk("re_ovf", overflow, 0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("re_col3", out_col, 50);
      @(negedge clk);
      out_ready = 1'b0;
      chk("re_done2", group_done, 1);
      chk("re_cnt2", out_cnt, 2);
      h_in = '0;
      for (int i = 0; i < 5; i++) set_ent(i + 20, $urandom_range(1, 255), i);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_col", out_col, 0);
      chk("arst_row", out_row, 0);
      chk("arst_last", out_last, 0);
      chk("arst_cnt", out_cnt, 0);
      chk("arst_done", group_done, 0);
      chk("arst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      h_in = '0;
      for (int i = 0; i < 6; i++) set_ent(34 - i * 5, $urandom_range(1, 255), $urandom_range(0, 63));
      model();
      run_group(0, 70);
      for (int g = 0; g < 30; g++) begin
         int nv;
         nv = (g == 5) ? 35 : $urandom_range(0, 35);
         h_in = '0;
         for (int i = 0; i < N; i++)
            if ($urandom_range(34) < nv)
               set_ent(i, (g % 3 == 0) ? $urandom_range(1, 8) : $urandom_range(1, 255), $urandom_range(0, 63));
         model();
         run_group($urandom_range(0, 2), $urandom_range(30, 100));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
